// File: rtl/phy_link_ctrl.sv
// -----------------------------------------------------------------------------
// phy_link_ctrl
//   Link-training and routing controller for the 4-lane phy.
//   After reset it forces the transmitter into sync-symbol transmission for
//   SYNC_CYCLES cycles, then waits (bounded by LOCK_TIMEOUT) for the receiver
//   to report lock. Once ACTIVE, lanes are routed to the transmitter, or to the
//   recirculator after IDLE_CYCLES idle cycles. Loss of lock, lock timeout and,
//   optionally, ERR_LIMIT consecutive receive errors trigger retraining.
//   Each retrain bumps a saturating 4-bit counter.
//
//   Optional feature macro: PHY_LINK_ERR_EN (receive-error retraining).
//
// Ports:
//   clk_f           in   block clock
//   reset           in   synchronous active-high reset
//   valid_in0..3_tx in   lane valids from the data source
//   rx_active       in   receiver lock indication
//   rx_err          in   receiver invalid-symbol flag (used with PHY_LINK_ERR_EN)
//   tx_sync_en      out  transmitter sends the sync symbol
//   route_tx        out  1: lanes to transmitter, 0: lanes to recirculator
//   lane_en[3:0]    out  per-lane transmit enable
//   link_state[1:0] out  0 RESET, 1 SYNC, 2 WAIT_LOCK, 3 ACTIVE
//   retrain_cnt[3:0]out  saturating retrain count
// -----------------------------------------------------------------------------
module phy_link_ctrl #(
    parameter int unsigned SYNC_CYCLES  = 4,
    parameter int unsigned LOCK_TIMEOUT = 16,
    parameter int unsigned IDLE_CYCLES  = 8,
    parameter int unsigned ERR_LIMIT    = 3
) (
    input  logic       clk_f,
    input  logic       reset,
    input  logic       valid_in0_tx,
    input  logic       valid_in1_tx,
    input  logic       valid_in2_tx,
    input  logic       valid_in3_tx,
    input  logic       rx_active,
    input  logic       rx_err,
    output logic       tx_sync_en,
    output logic       route_tx,
    output logic [3:0] lane_en,
    output logic [1:0] link_state,
    output logic [3:0] retrain_cnt
);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_SYNC      = 2'd1,
        ST_WAIT_LOCK = 2'd2,
        ST_ACTIVE    = 2'd3
    } state_t;

    localparam int unsigned SYNC_W = $clog2(SYNC_CYCLES + 1);
    localparam int unsigned TMR_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);

    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CYCLES);

    state_t              state, state_n;
    logic [SYNC_W-1:0]   sync_cnt, sync_n;
    logic [TMR_W-1:0]    timer, timer_n;
    logic [IDLE_W-1:0]   idle_cnt, idle_n;
    logic                idle_flag, idle_flag_n;
    logic                retrain;
    logic                any_valid;
    logic                tx_sync_n, route_n;
    logic [3:0]          lane_en_n;
    logic [3:0]          retrain_cnt_n;

`ifdef PHY_LINK_ERR_EN
    localparam int unsigned ERR_W   = $clog2(ERR_LIMIT + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(ERR_LIMIT);
    logic [ERR_W-1:0]    err_cnt, err_n;
`else
    localparam int unsigned unused_err_limit = ERR_LIMIT;
    logic unused_rx_err;
    assign unused_rx_err = rx_err;
`endif

    assign any_valid  = valid_in0_tx | valid_in1_tx | valid_in2_tx | valid_in3_tx;
    assign link_state = state;

    always_ff @(posedge clk_f) begin
        if (reset) begin
            state       <= ST_RESET;
            sync_cnt    <= '0;
            timer       <= '0;
            idle_cnt    <= '0;
            idle_flag   <= 1'b0;
            tx_sync_en  <= 1'b0;
            route_tx    <= 1'b0;
            lane_en     <= '0;
            retrain_cnt <= '0;
`ifdef PHY_LINK_ERR_EN
            err_cnt     <= '0;
`endif
        end else begin
            state       <= state_n;
            sync_cnt    <= sync_n;
            timer       <= timer_n;
            idle_cnt    <= idle_n;
            idle_flag   <= idle_flag_n;
            tx_sync_en  <= tx_sync_n;
            route_tx    <= route_n;
            lane_en     <= lane_en_n;
            retrain_cnt <= retrain_cnt_n;
`ifdef PHY_LINK_ERR_EN
            err_cnt     <= err_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        sync_n      = sync_cnt;
        timer_n     = timer;
        idle_n      = idle_cnt;
        idle_flag_n = idle_flag;
        retrain     = 1'b0;
`ifdef PHY_LINK_ERR_EN
        err_n       = err_cnt;
`endif

        case (state)
            ST_RESET: begin
                state_n = ST_SYNC;
            end
            ST_SYNC: begin
                if (sync_cnt == SYNC_LAST) begin
                    state_n = ST_WAIT_LOCK;
                end else begin
                    sync_n = sync_cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock seen on the timeout cycle still wins.
                if (rx_active) begin
                    state_n = ST_ACTIVE;
                end else if (timer == TMR_LAST) begin
                    state_n = ST_SYNC;
                    retrain = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (any_valid) begin
                    idle_n = '0;
                end else if (idle_cnt != IDLE_MAX) begin
                    idle_n = idle_cnt + 1'b1;
                end
                // The flag is released one edge after a valid: a zero count
                // here means the previous edge saw a valid.
                if (idle_n == IDLE_MAX) begin
                    idle_flag_n = 1'b1;
                end else if (idle_cnt == '0) begin
                    idle_flag_n = 1'b0;
                end
`ifdef PHY_LINK_ERR_EN
                if (!rx_err) begin
                    err_n = '0;
                end else if (err_cnt != ERR_MAX) begin
                    err_n = err_cnt + 1'b1;
                end
`endif
                if (!rx_active) begin
                    state_n = ST_SYNC;
                    retrain = 1'b1;
`ifdef PHY_LINK_ERR_EN
                end else if (err_n == ERR_MAX) begin
                    state_n = ST_SYNC;
                    retrain = 1'b1;
`endif
                end
            end
            default: begin
                state_n = ST_RESET;
            end
        endcase

        // Every state entry starts all counters afresh.
        if (state_n != state) begin
            sync_n      = '0;
            timer_n     = '0;
            idle_n      = '0;
            idle_flag_n = 1'b0;
`ifdef PHY_LINK_ERR_EN
            err_n       = '0;
`endif
        end

        tx_sync_n = (state_n == ST_SYNC) || (state_n == ST_WAIT_LOCK);
        lane_en_n = (state_n == ST_ACTIVE) ? 4'hF : 4'h0;
        route_n   = (state_n == ST_ACTIVE) && !idle_flag_n;

        retrain_cnt_n = (retrain && (retrain_cnt != 4'hF)) ? retrain_cnt + 4'd1
                                                            : retrain_cnt;
    end

endmodule

// File: tb/tb_phy_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_phy_link_ctrl
//   Self-checking bench for phy_link_ctrl. Directed scenarios plus a
//   randomized run, all compared against an edge-counting reference model.
// -----------------------------------------------------------------------------
module tb_phy_link_ctrl;

    localparam int SYNC_C = 4;
    localparam int LOCK_TO = 16;
    localparam int IDLE_C = 8;
    localparam int ERR_L = 3;
`ifdef PHY_LINK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk_f = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] vin = 4'h0;
    logic       rx_active = 1'b0;
    logic       rx_err = 1'b0;
    logic       tx_sync_en;
    logic       route_tx;
    logic [3:0] lane_en;
    logic [1:0] link_state;
    logic [3:0] retrain_cnt;
    logic [11:0] dut_vec;

    int passed = 0;
    int total  = 0;

    // Reference model: edge index, state entry edge, last-valid edge.
    int n = 0;
    int m_st = 0;
    int m_entry = 0;
    int m_lastv = 0;
    int m_lows_prev = 0;
    int m_err_run = 0;
    int m_retr = 0;
    bit m_route = 1'b0;

    phy_link_ctrl #(
        .SYNC_CYCLES (SYNC_C),
        .LOCK_TIMEOUT(LOCK_TO),
        .IDLE_CYCLES (IDLE_C),
        .ERR_LIMIT   (ERR_L)
    ) dut (
        .clk_f       (clk_f),
        .reset       (reset),
        .valid_in0_tx(vin[0]),
        .valid_in1_tx(vin[1]),
        .valid_in2_tx(vin[2]),
        .valid_in3_tx(vin[3]),
        .rx_active   (rx_active),
        .rx_err      (rx_err),
        .tx_sync_en  (tx_sync_en),
        .route_tx    (route_tx),
        .lane_en     (lane_en),
        .link_state  (link_state),
        .retrain_cnt (retrain_cnt)
    );

    assign dut_vec = {link_state, tx_sync_en, route_tx, lane_en, retrain_cnt};

    always #5 clk_f = ~clk_f;

    task automatic m_go(input int s);
        m_st        = s;
        m_entry     = n;
        m_lastv     = n;
        m_lows_prev = 0;
        m_err_run   = 0;
        m_route     = 1'b1;
    endtask

    task automatic m_retrain();
        m_go(1);
        if (m_retr < 15) m_retr++;
    endtask

    task automatic model_edge();
        int lows;
        n++;
        if (reset) begin
            m_st = 0;
            m_retr = 0;
            m_route = 1'b0;
        end else begin
            case (m_st)
                0: m_go(1);
                1: if (n - m_entry == SYNC_C) m_go(2);
                2: begin
                    if (rx_active) m_go(3);
                    else if (n - m_entry == LOCK_TO) m_retrain();
                end
                default: begin
                    m_err_run = rx_err ? m_err_run + 1 : 0;
                    if (vin != 4'h0) m_lastv = n;
                    lows = n - m_lastv;
                    // Recirculate while the low run has reached the limit,
                    // and for one more edge after the run is broken.
                    m_route = !((lows >= IDLE_C) || (m_lows_prev >= IDLE_C));
                    m_lows_prev = lows;
                    if (!rx_active) m_retrain();
                    else if (ERR_EN && m_err_run >= ERR_L) m_retrain();
                end
            endcase
        end
    endtask

    function automatic logic [11:0] exp_vec();
        logic act;
        act = (m_st == 3);
        return {2'(m_st), 1'(m_st == 1 || m_st == 2), act && m_route,
                act ? 4'hF : 4'h0, 4'(m_retr)};
    endfunction

    task automatic step();
        @(posedge clk_f);
        model_edge();
        #1;
    endtask

    task automatic bring_up();
        reset = 1'b1; rx_active = 1'b1; rx_err = 1'b0; vin = 4'hF;
        step();
        reset = 1'b0;
        repeat (SYNC_C + 2) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_active = 1'b1; vin = 4'hF;
        repeat (3) step();
        total++;
        if (dut_vec !== 12'h000) $display("FAIL reset_state: got %h expected %h", dut_vec, 12'h000);
        else passed++;
        total++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
        else passed++;
    endtask

    task automatic test_training();
        logic [1:0] exp_ls [0:5];
        exp_ls[0] = 2'd1; exp_ls[1] = 2'd1; exp_ls[2] = 2'd1;
        exp_ls[3] = 2'd1; exp_ls[4] = 2'd2; exp_ls[5] = 2'd3;
        reset = 1'b1; rx_active = 1'b1; rx_err = 1'b0; vin = 4'hF;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (link_state !== exp_ls[i] || tx_sync_en !== 1'(i < 5))
                $display("FAIL train_E%0d: got ls=%0d sync=%b expected ls=%0d sync=%b",
                         i, link_state, tx_sync_en, exp_ls[i], 1'(i < 5));
            else passed++;
        end
        total++;
        if (lane_en !== 4'hF || route_tx !== 1'b1 || retrain_cnt !== 4'd0)
            $display("FAIL train_active: got lane=%h route=%b retr=%0d expected lane=f route=1 retr=0",
                     lane_en, route_tx, retrain_cnt);
        else passed++;
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        reset = 1'b1; rx_active = 1'b0; vin = 4'h0;
        step();
        reset = 1'b0;
        for (int i = 0; i <= 15 * (SYNC_C + LOCK_TO) + 30; i++) begin
            step();
            if (i == SYNC_C + LOCK_TO) begin
                total++;
                if (link_state !== 2'd1 || retrain_cnt !== 4'd1)
                    $display("FAIL first_timeout: got ls=%0d retr=%0d expected ls=1 retr=1",
                             link_state, retrain_cnt);
                else passed++;
            end
            if (dut_vec !== exp_vec() && bad < 5) begin
                bad++;
                $display("FAIL timeout_model@%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        total++;
        if (bad != 0) $display("FAIL timeout_model: got %0d bad edges expected 0", bad);
        else passed++;
        total++;
        if (retrain_cnt !== 4'd15) $display("FAIL retrain_sat: got %0d expected 15", retrain_cnt);
        else passed++;
    endtask

    task automatic test_idle();
        bring_up();
        vin = 4'hF;
        step();
        vin = 4'h0;
        for (int i = 1; i <= IDLE_C; i++) begin
            step();
            total++;
            if (route_tx !== 1'(i < IDLE_C) || link_state !== 2'd3)
                $display("FAIL idle_%0d: got route=%b ls=%0d expected route=%b ls=3",
                         i, route_tx, link_state, 1'(i < IDLE_C));
            else passed++;
        end
        vin = 4'b0100;
        step();
        total++;
        if (route_tx !== 1'b0 || link_state !== 2'd3)
            $display("FAIL idle_valid_edge: got route=%b ls=%0d expected route=0 ls=3", route_tx, link_state);
        else passed++;
        vin = 4'h0;
        step();
        total++;
        if (route_tx !== 1'b1 || link_state !== 2'd3 || dut_vec !== exp_vec())
            $display("FAIL idle_restore: got %h expected %h", dut_vec, exp_vec());
        else passed++;
    endtask

    task automatic test_lock_loss();
        bring_up();
        rx_active = 1'b0;
        step();
        total++;
        if (link_state !== 2'd1 || lane_en !== 4'h0 || retrain_cnt !== 4'd1 ||
            route_tx !== 1'b0 || tx_sync_en !== 1'b1)
            $display("FAIL lock_loss: got %h expected %h", dut_vec, {2'd1, 1'b1, 1'b0, 4'h0, 4'd1});
        else passed++;
        rx_active = 1'b1;
        repeat (SYNC_C) step();
        total++;
        if (link_state !== 2'd2) $display("FAIL relock_wait: got %0d expected 2", link_state);
        else passed++;
        step();
        total++;
        if (link_state !== 2'd3 || retrain_cnt !== 4'd1 || lane_en !== 4'hF)
            $display("FAIL relock_active: got %h expected %h", dut_vec, {2'd3, 1'b0, 1'b1, 4'hF, 4'd1});
        else passed++;
    endtask

    task automatic test_err();
        bring_up();
        rx_err = 1'b1;
        repeat (2) step();
        rx_err = 1'b0;
        step();
        total++;
        if (link_state !== 2'd3 || retrain_cnt !== 4'd0)
            $display("FAIL err_two: got ls=%0d retr=%0d expected ls=3 retr=0", link_state, retrain_cnt);
        else passed++;
        rx_err = 1'b1;
        repeat (3) step();
        rx_err = 1'b0;
        total++;
        if (link_state !== (ERR_EN ? 2'd1 : 2'd3) || retrain_cnt !== (ERR_EN ? 4'd1 : 4'd0))
            $display("FAIL err_limit: got ls=%0d retr=%0d expected ls=%0d retr=%0d",
                     link_state, retrain_cnt, ERR_EN ? 1 : 3, ERR_EN ? 1 : 0);
        else passed++;
        // Error limit and lock loss on the same edge: one increment only.
        bring_up();
        rx_err = 1'b1;
        repeat (2) step();
        rx_active = 1'b0;
        step();
        rx_err = 1'b0; rx_active = 1'b1;
        total++;
        if (link_state !== 2'd1 || retrain_cnt !== 4'd1)
            $display("FAIL err_and_loss: got ls=%0d retr=%0d expected ls=1 retr=1", link_state, retrain_cnt);
        else passed++;
    endtask

    task automatic test_reset_midwait();
        reset = 1'b1; rx_active = 1'b0; rx_err = 1'b0; vin = 4'h0;
        step();
        reset = 1'b0;
        repeat (5 * (SYNC_C + LOCK_TO) + SYNC_C + 3) step();
        total++;
        if (link_state !== 2'd2 || retrain_cnt !== 4'd5)
            $display("FAIL midwait_setup: got ls=%0d retr=%0d expected ls=2 retr=5", link_state, retrain_cnt);
        else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (dut_vec !== 12'h000) $display("FAIL midwait_reset: got %h expected %h", dut_vec, 12'h000);
        else passed++;
        step();
        total++;
        if (link_state !== 2'd1 || tx_sync_en !== 1'b1)
            $display("FAIL midwait_resync: got ls=%0d sync=%b expected ls=1 sync=1", link_state, tx_sync_en);
        else passed++;
    endtask

    task automatic test_random();
        int bad;
        int mode;
        bad = 0;
        mode = 0;
        reset = 1'b1;
        step();
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) mode = $urandom_range(0, 2);
            reset     = ($urandom_range(0, 599) == 0);
            rx_active = (mode == 1) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 39) != 0);
            rx_err    = (mode == 2) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
            vin       = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            step();
            if (dut_vec !== exp_vec() && bad < 5) begin
                $display("FAIL random@%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            if (dut_vec !== exp_vec()) bad++;
        end
        reset = 1'b0;
        total++;
        if (bad != 0) $display("FAIL random_model: got %0d bad edges expected 0", bad);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_training();
        test_timeout();
        test_idle();
        test_lock_loss();
        test_err();
        test_reset_midwait();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/phy_link_ctrl.md
# phy_link_ctrl

Link-training and routing controller for the 4-lane phy, clocked on `clk_f`. After reset it drives the transmitter into sync-symbol transmission and waits for the receiver to report lock. It then routes lane traffic through the transmitter, or back through the recirculator when the lanes are idle. Loss of lock, a lock timeout, or (optionally) repeated receive errors trigger retraining, and a saturating counter records each retrain.

## Interface
Parameters:
- `SYNC_CYCLES`, 4: `clk_f` cycles of forced sync transmission per training attempt (≥1).
- `LOCK_TIMEOUT`, 16: consecutive WAIT_LOCK cycles without `rx_active` before retraining (≥1).
- `IDLE_CYCLES`, 8: consecutive cycles with all four valids low before recirculating (≥1).
- `ERR_LIMIT`, 3: consecutive `rx_err` cycles in ACTIVE that force retraining (≥1). Used only with `PHY_LINK_ERR_EN`.

Ports:
- `clk_f` in 1: the block's only clock.
- `reset` in 1: synchronous, active-high.
- `valid_in0_tx`..`valid_in3_tx` in 1 each: lane valids from the data source.
- `rx_active` in 1: receiver sync/lock indication.
- `rx_err` in 1: receiver invalid-symbol flag.
- `tx_sync_en` out 1: transmitter sends the sync symbol instead of data.
- `route_tx` out 1: 1 routes lanes to the transmitter; 0 routes lanes to the recirculator.
- `lane_en` out 4: per-lane transmit enable. Bit i corresponds to lane i.
- `link_state` out 2: RESET=0, SYNC=1, WAIT_LOCK=2, ACTIVE=3.
- `retrain_cnt` out 4: saturating count of retrains.

## Operation
- All outputs are registered. All inputs are sampled on the rising edge of `clk_f`.
- Reset (`reset`=1 at an edge) applies the following values:
  - `link_state`=RESET, `tx_sync_en`=0, `route_tx`=0, `lane_en`=0, `retrain_cnt`=0.
  - All internal counters clear.
  - Reset asserted in any state returns the block here on that edge. `retrain_cnt` is not incremented by reset.
- RESET: on the first edge with `reset`=0, go to SYNC.
- SYNC:
  - `tx_sync_en`=1, `route_tx`=0, `lane_en`=0.
  - The state lasts exactly `SYNC_CYCLES` cycles, then goes to WAIT_LOCK. `rx_active` is ignored in SYNC.
- WAIT_LOCK:
  - `tx_sync_en`=1; the timer starts at 0 on entry.
  - If `rx_active`=1, go to ACTIVE.
  - Otherwise, when the timer reaches `LOCK_TIMEOUT`, go to SYNC and increment `retrain_cnt`.
  - If `rx_active` rises on the timeout cycle, `rx_active` wins and the block goes to ACTIVE.
- ACTIVE:
  - `tx_sync_en`=0 and `lane_en`=4'b1111.
  - `route_tx`=1 unless the idle flag is set.
  - Idle counter: increments each cycle all four valids are 0 and clears when any valid is 1. The idle flag sets when the counter reaches `IDLE_CYCLES` and clears on the edge after any valid is 1.
  - `rx_active`=0 in ACTIVE: go to SYNC and increment `retrain_cnt`.
- Retrain exits from any state force `lane_en`=0 and `route_tx`=0 on the same edge.
- `retrain_cnt` saturates at 15 and never wraps.
- Counters are sized to hold their parameter value. Timer, idle and error counters reset on every state entry.

## Timing
- Time origin: edge E0 is the first edge with `reset`=0.
- Training sequence:
  - E0: `link_state` becomes SYNC and `tx_sync_en` becomes 1.
  - E0+`SYNC_CYCLES`: `link_state` becomes WAIT_LOCK.
  - With `rx_active` already high: ACTIVE is reached at E0+`SYNC_CYCLES`+1. The minimum reset-to-ACTIVE time is `SYNC_CYCLES`+1 edges.
- Exit from ACTIVE on `rx_active` falling: one-cycle latency, i.e. SYNC is visible on the edge after `rx_active`=0 is sampled.
- Idle transition: with the last valid sampled high at edge k, `route_tx` falls at edge k+`IDLE_CYCLES`. A valid sampled at edge j restores `route_tx`=1 at edge j+1.
- Simultaneous events in ACTIVE: loss of lock takes priority over idle and error handling. Only one `retrain_cnt` increment occurs per exit.

## Configuration
- Macro: `PHY_LINK_ERR_EN`.
- Defined:
  - In ACTIVE, an error counter increments on each `rx_err`=1 cycle and clears on `rx_err`=0.
  - Reaching `ERR_LIMIT` goes to SYNC and increments `retrain_cnt`.
  - If `rx_err` and `rx_active`=0 coincide, only one increment occurs.
- Undefined: `rx_err` is ignored, the port remains, and no error counter is synthesized.

## Test plan
- Reset released, `rx_active`=1 constant:
  - `tx_sync_en`=1 for edges E0..E4 and `link_state` 1,1,1,1,2.
  - ACTIVE at E5 with `lane_en`=4'hF, `route_tx`=1.
- `rx_active`=0 constant:
  - Cycles SYNC(4) → WAIT_LOCK(16) → SYNC repeatedly.
  - `retrain_cnt` increments each timeout and holds 15 after the 15th timeout.
- In ACTIVE, all valids low for 8 cycles: `route_tx`=0 at the 8th edge. `valid_in2_tx`=1 for one cycle gives `route_tx`=1 on the next edge; `link_state` stays 3 throughout.
- In ACTIVE, drop `rx_active` for one cycle: next edge gives `link_state`=1, `lane_en`=0, `retrain_cnt`+1, then automatic retraining.
- With `PHY_LINK_ERR_EN`:
  - `rx_err`=1 for 2 cycles, then 0: stays ACTIVE.
  - `rx_err`=1 for 3 cycles: SYNC and `retrain_cnt`+1.
  - Without the macro, the same stimulus stays ACTIVE.
- Assert `reset` mid-WAIT_LOCK with `retrain_cnt`=5: next edge shows all outputs 0, `link_state`=0 and `retrain_cnt`=0.
